// File: rtl/cu_pkg.sv
// cu_pkg: opcode, ALU code, flag bit and FSM state definitions shared by the decode stage
package cu_pkg;
  localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_AND = 4'd4,
                         OP_OR = 4'd5, OP_ROT = 4'd6, OP_STK = 4'd7, OP_UNA = 4'd8, OP_GRP = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_PASS = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3, ALU_AND = 4'd4,
                         ALU_OR = 4'd5, ALU_RLC = 4'd6, ALU_RRC = 4'd7, ALU_SETC = 4'd8, ALU_CLRC = 4'd9,
                         ALU_NOT = 4'd10, ALU_NEG = 4'd11, ALU_INC = 4'd12, ALU_DEC = 4'd13;
  localparam int FLG_Z = 0, FLG_N = 1, FLG_C = 2, FLG_V = 3;
  localparam logic [3:0] FM_ALL = 4'((1 << FLG_Z) | (1 << FLG_N) | (1 << FLG_C) | (1 << FLG_V));
  localparam logic [3:0] FM_ZN = 4'((1 << FLG_Z) | (1 << FLG_N));
  localparam logic [3:0] FM_C = 4'(1 << FLG_C);
  typedef enum logic {OPC, IMM} state_e;
endpackage

// File: rtl/cu_decode_comb.sv
// cu_decode_comb: combinational instruction decode, IR in, control bundle out
// ir in; two_byte flags the opcode-12 group; remaining outputs mirror the decode_stage bundle (minus imm)
module cu_decode_comb #(
  parameter int REG_IDX_W = 2,
  localparam int IR_W = 4 + 2 * REG_IDX_W
) (
  input  logic [IR_W-1:0]      ir,
  output logic                 two_byte,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] dst_reg,
  output logic [REG_IDX_W-1:0] src_a,
  output logic [REG_IDX_W-1:0] src_b,
  output logic [3:0]           alu_sel,
  output logic [1:0]           op2_sel,
  output logic [1:0]           wb_sel,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic [3:0]           flag_mask,
  output logic                 illegal
);
  import cu_pkg::*;
  logic [3:0] opc, op;
  logic [REG_IDX_W-1:0] ra, rb;
  int unsigned sub;
  logic ill;
  assign opc = ir[IR_W-1 -: 4];
  assign ra = ir[IR_W-5 -: REG_IDX_W];
  assign rb = ir[REG_IDX_W-1:0];
  assign sub = 32'(ra);
  // sub-opcodes beyond 3 only exist for wider register indices and are undefined
  assign ill = (opc > OP_UNA && opc != OP_GRP) || (opc == OP_GRP && sub == 3) || (opc >= OP_ROT && sub > 3);
  assign op = ill ? OP_NOP : opc;
  assign two_byte = opc == OP_GRP;
  assign src_a = ra;
  assign src_b = rb;
  assign illegal = ill;
  always_comb begin
    reg_write = 1'b0;
    dst_reg = '0;
    alu_sel = ALU_NOP;
    op2_sel = 2'b00;
    wb_sel = 2'b00;
    mem_read = 1'b0;
    mem_write = 1'b0;
    io_read = 1'b0;
    io_write = 1'b0;
    flag_mask = 4'b0000;
    case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        reg_write = 1'b1;
        dst_reg = ra;
        alu_sel = op == OP_MOV ? ALU_PASS : op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB :
                  op == OP_AND ? ALU_AND : ALU_OR;
        flag_mask = op == OP_MOV ? 4'b0000 : (op == OP_ADD || op == OP_SUB) ? FM_ALL : FM_ZN;
      end
      OP_ROT: begin
        dst_reg = rb;
        reg_write = sub < 2;
        alu_sel = sub == 0 ? ALU_RLC : sub == 1 ? ALU_RRC : sub == 2 ? ALU_SETC : ALU_CLRC;
        flag_mask = FM_C;
      end
      OP_STK: begin
        dst_reg = rb;
        mem_write = sub == 0;
        mem_read = sub == 1;
        io_write = sub == 2;
        io_read = sub == 3;
        reg_write = sub == 1 || sub == 3;
        wb_sel = {1'b0, reg_write};
        alu_sel = (sub == 0 || sub == 2) ? ALU_PASS : ALU_NOP;
        flag_mask = sub == 1 ? FM_ZN : 4'b0000;
      end
      OP_UNA: begin
        dst_reg = rb;
        reg_write = 1'b1;
        alu_sel = sub == 0 ? ALU_NOT : sub == 1 ? ALU_NEG : sub == 2 ? ALU_INC : ALU_DEC;
        flag_mask = sub == 0 ? FM_ZN : FM_ALL;
      end
      OP_GRP: begin
        dst_reg = rb;
        reg_write = sub < 2;
        op2_sel = sub == 0 ? 2'b01 : 2'b00;
        alu_sel = sub == 0 ? ALU_PASS : ALU_NOP;
        mem_read = sub == 1;
        wb_sel = {1'b0, sub == 1};
        mem_write = sub == 2;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode pipeline stage with valid/ready handshake and two-byte immediate assembly
// fetch side: in_valid/in_ready/in_word, flush; execute side: out_valid/ex_ready plus the registered bundle
module decode_stage #(
  parameter int REG_IDX_W = 2,
  parameter int DATA_W = 8,
  localparam int IR_W = 4 + 2 * REG_IDX_W,
  localparam int WORD_W = IR_W > DATA_W ? IR_W : DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_word,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 out_valid,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] dst_reg,
  output logic [REG_IDX_W-1:0] src_a,
  output logic [REG_IDX_W-1:0] src_b,
  output logic [3:0]           alu_sel,
  output logic [1:0]           op2_sel,
  output logic [1:0]           wb_sel,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic [3:0]           flag_mask,
  output logic [DATA_W-1:0]    imm,
  output logic                 illegal
);
  import cu_pkg::*;
  localparam int BW = 18 + 3 * REG_IDX_W;
  state_e state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d, dec_ir;
  logic [BW-1:0] b_q, b_d, dec_b;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic out_valid_q, out_valid_d, xfer, two_byte;
  logic d_rw, d_mr, d_mw, d_ior, d_iow, d_ill;
  logic [REG_IDX_W-1:0] d_dst, d_sa, d_sb;
  logic [3:0] d_alu, d_fm;
  logic [1:0] d_op2, d_wb;
  assign in_ready = !out_valid_q || ex_ready;
  assign xfer = in_valid && in_ready;
  // in IMM the held opcode is decoded while the incoming word supplies the immediate
  assign dec_ir = state_q == IMM ? ir_q : in_word[IR_W-1:0];
  cu_decode_comb #(.REG_IDX_W(REG_IDX_W)) u_dec (
    .ir(dec_ir), .two_byte(two_byte), .reg_write(d_rw), .dst_reg(d_dst), .src_a(d_sa), .src_b(d_sb),
    .alu_sel(d_alu), .op2_sel(d_op2), .wb_sel(d_wb), .mem_read(d_mr), .mem_write(d_mw),
    .io_read(d_ior), .io_write(d_iow), .flag_mask(d_fm), .illegal(d_ill)
  );
  assign dec_b = {d_rw, d_dst, d_sa, d_sb, d_alu, d_op2, d_wb, d_mr, d_mw, d_ior, d_iow, d_fm, d_ill};
  assign {reg_write, dst_reg, src_a, src_b, alu_sel, op2_sel, wb_sel, mem_read, mem_write, io_read, io_write,
          flag_mask, illegal} = b_q;
  assign imm = imm_q;
  assign out_valid = out_valid_q;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    b_d = b_q;
    imm_d = imm_q;
    out_valid_d = out_valid_q && !ex_ready;
    if (flush) begin
      state_d = OPC;
      ir_d = '0;
      out_valid_d = 1'b0;
    end else if (xfer && state_q == OPC && two_byte) begin
      state_d = IMM;
      ir_d = in_word[IR_W-1:0];
    end else if (xfer) begin
      state_d = OPC;
      ir_d = '0;
      out_valid_d = 1'b1;
      b_d = dec_b;
      imm_d = (state_q == IMM && !d_ill) ? in_word[DATA_W-1:0] : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OPC;
      ir_q <= '0;
      b_q <= '0;
      imm_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      b_q <= b_d;
      imm_q <= imm_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with per-scenario check tasks
module tb_decode_stage;
  typedef struct packed {
    logic rw; logic [1:0] dst, sa, sb; logic [3:0] alu; logic [1:0] op2, wb;
    logic mr, mw, ior, iow; logic [3:0] fm; logic ill; logic [7:0] imm;
  } bun_t;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, ex_ready = 0;
  logic [7:0] in_word = 0;
  logic in_ready, out_valid, reg_write, mem_read, mem_write, io_read, io_write, illegal;
  logic [1:0] dst_reg, src_a, src_b, op2_sel, wb_sel;
  logic [3:0] alu_sel, flag_mask;
  logic [7:0] imm;
  bun_t obs, e;
  bun_t sb[$];
  int n = 0, nf = 0;
  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .flush(flush),
    .ex_ready(ex_ready), .out_valid(out_valid), .reg_write(reg_write), .dst_reg(dst_reg), .src_a(src_a),
    .src_b(src_b), .alu_sel(alu_sel), .op2_sel(op2_sel), .wb_sel(wb_sel), .mem_read(mem_read),
    .mem_write(mem_write), .io_read(io_read), .io_write(io_write), .flag_mask(flag_mask), .imm(imm),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs = {reg_write, dst_reg, src_a, src_b, alu_sel, op2_sel, wb_sel, mem_read, mem_write, io_read,
                io_write, flag_mask, illegal, imm};
  function automatic bun_t model(input logic [7:0] ir, input logic [7:0] im);
    bun_t b;
    logic [1:0] a, r;
    b = '0;
    a = ir[3:2];
    r = ir[1:0];
    b.sa = a;
    b.sb = r;
    case (ir[7:4])
      4'd0: ;
      4'd1: begin b.rw = 1; b.dst = a; b.alu = 4'd1; end
      4'd2: begin b.rw = 1; b.dst = a; b.alu = 4'd2; b.fm = 4'b1111; end
      4'd3: begin b.rw = 1; b.dst = a; b.alu = 4'd3; b.fm = 4'b1111; end
      4'd4: begin b.rw = 1; b.dst = a; b.alu = 4'd4; b.fm = 4'b0011; end
      4'd5: begin b.rw = 1; b.dst = a; b.alu = 4'd5; b.fm = 4'b0011; end
      4'd6: begin b.dst = r; b.fm = 4'b0100; b.alu = 4'd6 + 4'(a); b.rw = a < 2; end
      4'd7: begin
        b.dst = r;
        case (a)
          2'd0: begin b.mw = 1; b.alu = 4'd1; end
          2'd1: begin b.mr = 1; b.rw = 1; b.wb = 2'b01; b.fm = 4'b0011; end
          2'd2: begin b.iow = 1; b.alu = 4'd1; end
          default: begin b.ior = 1; b.rw = 1; b.wb = 2'b01; end
        endcase
      end
      4'd8: begin b.rw = 1; b.dst = r; b.alu = 4'd10 + 4'(a); b.fm = a == 0 ? 4'b0011 : 4'b1111; end
      4'd12: begin
        case (a)
          2'd0: begin b.dst = r; b.rw = 1; b.op2 = 2'b01; b.alu = 4'd1; b.imm = im; end
          2'd1: begin b.dst = r; b.mr = 1; b.rw = 1; b.wb = 2'b01; b.imm = im; end
          2'd2: begin b.dst = r; b.mw = 1; b.imm = im; end
          default: b.ill = 1;
        endcase
      end
      default: b.ill = 1;
    endcase
    return b;
  endfunction
  task automatic test_reset;
    rst_n = 0;
    #1;
    n++;
    if ({out_valid, obs} !== '0) begin nf++; $display("FAIL reset_out: got %h want 0", {out_valid, obs}); end
    n++;
    if (in_ready !== 1'b1) begin nf++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic test_add;
    ex_ready = 1;
    in_valid = 1;
    in_word = 8'h26;
    @(posedge clk);
    #1 in_valid = 0;
    n++;
    if ({out_valid, dst_reg, src_b, alu_sel, flag_mask, reg_write} !== {1'b1, 2'd1, 2'd2, 4'd2, 4'hF, 1'b1}) begin
      nf++;
      $display("FAIL add: got v=%b dst=%0d sb=%0d alu=%0d fm=%b rw=%b want 1 1 2 2 1111 1",
               out_valid, dst_reg, src_b, alu_sel, flag_mask, reg_write);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back;
    logic [7:0] w [18] = '{8'h00, 8'h1B, 8'h26, 8'h37, 8'h45, 8'h5A, 8'h61, 8'h66, 8'h69,
                           8'h6E, 8'h71, 8'h76, 8'h7B, 8'h7E, 8'h82, 8'h87, 8'h8A, 8'h8F};
    ex_ready = 1;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1;
      in_word = w[i];
      sb.push_back(model(w[i], 8'h00));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n++;
      if (out_valid !== 1'b1 || obs !== e) begin
        nf++;
        $display("FAIL b2b %h: got v=%b %h want v=1 %h", w[i], out_valid, obs, e);
      end
    end
    in_valid = 0;
    @(posedge clk);
    #1;
    n++;
    if (out_valid !== 1'b0) begin nf++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_two_byte;
    logic [7:0] p [4][2] = '{'{8'hC3, 8'h5A}, '{8'hC6, 8'h80}, '{8'hC9, 8'h11}, '{8'hCD, 8'h33}};
    ex_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_word = p[i][0];
      @(posedge clk);
      #1;
      n++;
      if (out_valid !== 1'b0) begin nf++; $display("FAIL grp_first %h: got v=%b want 0", p[i][0], out_valid); end
      in_word = p[i][1];
      sb.push_back(model(p[i][0], p[i][1]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n++;
      if (out_valid !== 1'b1 || obs !== e) begin
        nf++;
        $display("FAIL grp %h %h: got v=%b %h want v=1 %h", p[i][0], p[i][1], out_valid, obs, e);
      end
      in_valid = 0;
      @(posedge clk);
      #1;
      n++;
      if (out_valid !== 1'b0) begin nf++; $display("FAIL grp_once %h: got v=%b want 0", p[i][0], out_valid); end
    end
  endtask
  task automatic test_backpressure;
    ex_ready = 0;
    in_valid = 1;
    in_word = 8'h3E;
    sb.push_back(model(8'h3E, 8'h00));
    @(posedge clk);
    #1;
    in_word = 8'h45;
    sb.push_back(model(8'h45, 8'h00));
    for (int i = 0; i < 5; i++) begin
      #1;
      n++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== sb[0]) begin
        nf++;
        $display("FAIL bp_hold %0d: got rdy=%b v=%b %h want rdy=0 v=1 %h", i, in_ready, out_valid, obs, sb[0]);
      end
      @(posedge clk);
      #1;
    end
    ex_ready = 1;
    #1;
    e = sb.pop_front();
    n++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs !== e) begin
      nf++;
      $display("FAIL bp_release: got rdy=%b v=%b %h want rdy=1 v=1 %h", in_ready, out_valid, obs, e);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    e = sb.pop_front();
    n++;
    if (out_valid !== 1'b1 || obs !== e) begin nf++; $display("FAIL bp_next: got v=%b %h want v=1 %h", out_valid, obs, e); end
  endtask
  task automatic test_flush;
    ex_ready = 1;
    in_valid = 1;
    in_word = 8'hC1;
    @(posedge clk);
    #1;
    flush = 1;
    in_word = 8'h26;
    @(posedge clk);
    #1;
    n++;
    if (out_valid !== 1'b0) begin nf++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    flush = 0;
    sb.push_back(model(8'h26, 8'h00));
    @(posedge clk);
    #1;
    in_valid = 0;
    e = sb.pop_front();
    n++;
    if (out_valid !== 1'b1 || obs !== e) begin nf++; $display("FAIL flush_after: got v=%b %h want v=1 %h", out_valid, obs, e); end
  endtask
  task automatic test_illegal;
    logic [7:0] w [6] = '{8'hF0, 8'h90, 8'hA5, 8'hB3, 8'hD2, 8'hE1};
    ex_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_word = w[i];
      sb.push_back(model(w[i], 8'h00));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n++;
      if (out_valid !== 1'b1 || obs !== e) begin nf++; $display("FAIL ill %h: got v=%b %h want v=1 %h", w[i], out_valid, obs, e); end
      if (i == 0) begin
        n++;
        if ({illegal, reg_write, mem_read, mem_write, io_read, io_write, out_valid} !== 7'b1000001) begin
          nf++;
          $display("FAIL ill_f0: got %b want 1000001", {illegal, reg_write, mem_read, mem_write, io_read, io_write, out_valid});
        end
      end
    end
    in_valid = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_imm;
    ex_ready = 1;
    in_valid = 1;
    in_word = 8'h26;
    @(posedge clk);
    #1 in_word = 8'hC2;
    @(posedge clk);
    #1 in_valid = 0;
    rst_n = 0;
    #1;
    n++;
    if ({out_valid, obs} !== '0 || in_ready !== 1'b1) begin
      nf++;
      $display("FAIL rst_imm: got v=%b %h rdy=%b want 0 0 1", out_valid, obs, in_ready);
    end
    #2 rst_n = 1;
    in_valid = 1;
    in_word = 8'h26;
    sb.push_back(model(8'h26, 8'h00));
    @(posedge clk);
    #1 in_valid = 0;
    e = sb.pop_front();
    n++;
    if (out_valid !== 1'b1 || obs !== e) begin nf++; $display("FAIL rst_after: got v=%b %h want v=1 %h", out_valid, obs, e); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_two_byte();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_imm();
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter REG_IDX_W, default 2, meaning register-index width (2**REG_IDX_W registers).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning immediate/data width.
REQ-003 The block SHALL derive IR_W = 4 + 2*REG_IDX_W, with opcode in [IR_W-1:IR_W-4], ra next, rb lowest.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  fetch word valid
- in_ready  out  1  decode can accept a word
- in_word  in  max(IR_W,DATA_W)  instruction or immediate word; IR taken from the low IR_W bits, immediate from the low DATA_W bits
- flush  in  1  discard in-flight decode
- ex_ready  in  1  execute stage accepts bundle
- out_valid  out  1  bundle valid
- reg_write  out  1  write register file at WB
- dst_reg, src_a, src_b  out  REG_IDX_W  destination, ra, rb indices
- alu_sel  out  4  ALU operation
- op2_sel  out  2  00=rb, 01=imm
- wb_sel  out  2  00=ALU, 01=MEM/IO
- mem_read, mem_write, io_read, io_write  out  1 each  access kind
- flag_mask  out  4  bit0 Z, bit1 N, bit2 C, bit3 V
- imm  out  DATA_W  immediate / address byte
- illegal  out  1  undefined opcode

Function
REQ-006 A word SHALL transfer only when in_valid && in_ready.
REQ-007 in_ready SHALL equal !out_valid || ex_ready; in_ready is combinational.
REQ-008 The FSM SHALL have states OPC (expecting an opcode) and IMM (expecting the second byte).
REQ-009 In OPC, on a transferred single-byte opcode the decoded bundle SHALL be registered with out_valid=1 on the next edge (latency 1).
REQ-010 In OPC, on transferred opcode 12 (two-byte group) the IR SHALL be held, the FSM SHALL enter IMM, and out_valid SHALL not be raised for it.
REQ-011 In IMM, the next transferred word SHALL be latched into imm, the bundle SHALL be emitted with out_valid=1 on the next edge, and the FSM SHALL return to OPC.
REQ-012 out_valid and every bundle field SHALL stay stable while out_valid && !ex_ready.
REQ-013 out_valid SHALL clear on an edge with ex_ready=1 and no new completed instruction; back-to-back completions SHALL keep out_valid=1.
REQ-014 Opcodes 0-8 SHALL decode as: NOP; MOV; ADD; SUB; AND; OR; 6=RLC/RRC/SETC/CLRC by ra; 7=PUSH/POP/OUT/IN by ra; 8=NOT/NEG/INC/DEC by ra. dst_reg SHALL be ra for opcodes 1-5 and rb for opcodes 6-8.
REQ-015 Flag masks SHALL be: ADD/SUB/NEG/INC/DEC 1111; AND/OR/NOT/POP 0011; RLC/RRC/SETC/CLRC 0100; all others 0000.
REQ-016 OUT SHALL assert io_write and IN SHALL assert io_read, with wb_sel=01 and dst_reg=rb for IN. PUSH SHALL assert mem_write and POP SHALL assert mem_read, with wb_sel=01 and dst_reg=rb for POP.
REQ-017 Opcode 12 SHALL decode by ra as follows, with dst_reg=rb:
- ra=0 LDM: reg_write, op2_sel=01, alu PASS
- ra=1 LDD: mem_read, reg_write, wb_sel=01
- ra=2 STD: mem_write
- ra=3: illegal
REQ-018 Opcodes 9-11 and 13-15, and 12/ra=3, SHALL emit a NOP bundle with illegal=1 and all write/access strobes 0.
REQ-019 flush SHALL, on the next edge, clear out_valid, force state OPC and discard any held IR; flush SHALL take priority over a same-cycle transfer.
REQ-020 imm SHALL be 0 for single-byte instructions.

Reset
REQ-021 While rst_n=0 the block SHALL hold state=OPC, out_valid=0, held IR=0, and all bundle outputs=0.
REQ-022 Reset asserted while in IMM SHALL discard the partial instruction.

Structure
REQ-023 Package cu_pkg SHALL hold the opcode constants, the ALU codes (NOP0 PASS1 ADD2 SUB3 AND4 OR5 RLC6 RRC7 SETC8 CLRC9 NOT A NEG B INC C DEC D), the flag bit positions and the FSM state type.
REQ-024 Combinational decode SHALL live in sub-module cu_decode_comb (IR in, bundle out), instantiated once.

Verification
REQ-025 ADD scenario: in_word=0x26, ex_ready=1 -> next cycle out_valid=1, dst_reg=1, src_b=2, alu_sel=2, flag_mask=1111, reg_write=1.
REQ-026 LDM scenario: 0xC3 then 0x5A -> out_valid stays 0 after the first word; after the second, one bundle with dst_reg=3, imm=0x5A, op2_sel=01, reg_write=1.
REQ-027 Backpressure scenario: ex_ready=0 with a bundle held -> in_ready=0 and the bundle is unchanged for 5 cycles; ex_ready=1 -> accepted and the next word transfers.
REQ-028 Flush scenario: 0xC1 transferred, then flush=1 with in_valid=1 -> out_valid=0, state OPC, no bundle emitted for 0xC1.
REQ-029 Illegal scenario: in_word=0xF0 -> illegal=1, reg_write=0, mem_*/io_*=0, out_valid=1.
REQ-030 Reset scenario: rst_n pulsed low while in IMM -> all outputs 0 immediately; 0x26 afterwards decodes normally.
